// File: rtl/debouncer_botoes_if.sv
// Button bundle between the raw pad side and the debouncer.
// Outputs carry no handshake: pressao/soltura/longo are single-cycle strobes, estado is a level.
interface debouncer_botoes_if #(
   parameter int N = 4
);
   logic [N-1:0] entrada;
   logic [N-1:0] pressao;
   logic [N-1:0] soltura;
   logic [N-1:0] longo;
   logic [N-1:0] estado;

   modport master (
      output entrada,
      input  pressao,
      input  soltura,
      input  longo,
      input  estado
   );

   modport slave (
      input  entrada,
      output pressao,
      output soltura,
      output longo,
      output estado
   );
endinterface

// File: rtl/debouncer_botoes.sv
// N independent button debouncers with press/release strobes and a long-press
// strobe that optionally auto-repeats while the button stays held.
module debouncer_botoes #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLD_CYCLES     = 1000,
   parameter int REPEAT_CYCLES   = 0,
   parameter int ACTIVE_LOW      = 1
) (
   input logic               CLOCK,
   input logic               RESET,
   debouncer_botoes_if.slave bus
);

   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);
   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

   logic [N-1:0]  raw;
   logic [N-1:0]  s1;
   logic [N-1:0]  s2;
   logic [N-1:0]  est;
   logic [N-1:0]  pressao_q;
   logic [N-1:0]  soltura_q;
   logic [N-1:0]  longo_q;
   // rep marks that the first long-press strobe has fired and hcnt now times repeats
   logic [N-1:0]  rep;
   logic [DW-1:0] dcnt [N];
   logic [HW-1:0] hcnt [N];

   logic [N-1:0]  change;
   logic [N-1:0]  accept;
   logic [N-1:0]  fire;

   always_comb begin
      raw    = (ACTIVE_LOW != 0) ? ~bus.entrada : bus.entrada;
      change = '0;
      accept = '0;
      fire   = '0;
      for (int i = 0; i < N; i++) begin
         change[i] = s2[i] ^ est[i];
         accept[i] = change[i] && (dcnt[i] == DB_LAST);
         fire[i]   = rep[i] ? (hcnt[i] == REP_LAST) : (hcnt[i] == HOLD_LAST);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         s1        <= '0;
         s2        <= '0;
         est       <= '0;
         pressao_q <= '0;
         soltura_q <= '0;
         longo_q   <= '0;
         rep       <= '0;
         for (int i = 0; i < N; i++) begin
            dcnt[i] <= '0;
            hcnt[i] <= '0;
         end
      end else begin
         s1        <= raw;
         s2        <= s1;
         pressao_q <= accept & s2;
         soltura_q <= accept & ~s2;
         for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
               est[i]  <= s2[i];
               dcnt[i] <= '0;
            end else if (change[i]) begin
               dcnt[i] <= dcnt[i] + 1'b1;
            end else begin
               dcnt[i] <= '0;
            end

            // A falling edge (accept while pressed) clears the hold timer on the same edge
            longo_q[i] <= 1'b0;
            if (!est[i] || accept[i]) begin
               hcnt[i] <= '0;
               rep[i]  <= 1'b0;
            end else if (fire[i]) begin
               longo_q[i] <= 1'b1;
               if (REPEAT_CYCLES > 0) begin
                  hcnt[i] <= '0;
                  rep[i]  <= 1'b1;
               end else begin
                  hcnt[i] <= HOLD_SAT;
               end
            end else if (rep[i] || (hcnt[i] != HOLD_SAT)) begin
               hcnt[i] <= hcnt[i] + 1'b1;
            end
         end
      end
   end

   assign bus.pressao = pressao_q;
   assign bus.soltura = soltura_q;
   assign bus.longo   = longo_q;
   assign bus.estado  = est;

endmodule

// File: tb/tb_debouncer_botoes.sv
// Scoreboard bench: stimulus pushes time-stamped expected strobe events, a negedge
// monitor pops one per observed strobe cycle and compares cycle, strobes and estado.
module tb_debouncer_botoes;
   localparam int N  = 4;
   localparam int DC = 4;
   localparam int HC = 10;
   localparam int RC = 3;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   // {cycle[15:0], pressao, soltura, longo, estado}
   logic [31:0] exp_q[$];
   logic [31:0] got_ev;
   logic [31:0] exp_ev;

   debouncer_botoes_if #(.N(N)) bus ();

   debouncer_botoes #(
      .N(N), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .ACTIVE_LOW(1)
   ) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [31:0] ev(input int t, input logic [3:0] p, input logic [3:0] s,
                                      input logic [3:0] l, input logic [3:0] e);
      logic [15:0] tt;
      tt = t[15:0];
      return {tt, p, s, l, e};
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   // Hold the channels in mask pressed (low) for 'hold' cycles, then release.
   task automatic press_hold(input logic [3:0] mask, input int hold);
      int t0, p, f;
      @(negedge CLOCK);
      t0 = cyc;
      p  = t0 + DC + 2;
      f  = t0 + hold + DC + 2;
      exp_q.push_back(ev(p, mask, 4'b0, 4'b0, mask));
      for (int t = p + HC; t < f; t += RC) exp_q.push_back(ev(t, 4'b0, 4'b0, mask, mask));
      exp_q.push_back(ev(f, 4'b0, mask, 4'b0, 4'b0));
      bus.entrada = bus.entrada & ~mask;
      idle(hold);
      bus.entrada = bus.entrada | mask;
      idle(12);
   endtask

   // Short low glitch that must be rejected
   task automatic glitch(input int ch, input int len);
      @(negedge CLOCK);
      bus.entrada[ch] = 1'b0;
      idle(len);
      bus.entrada[ch] = 1'b1;
      idle(12);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge CLOCK) begin
      if (RESET && ((|bus.pressao) || (|bus.soltura) || (|bus.longo))) begin
         got_ev = ev(cyc, bus.pressao, bus.soltura, bus.longo, bus.estado);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got=%h required=none", got_ev);
         end else begin
            exp_ev = exp_q.pop_front();
            if (got_ev !== exp_ev) begin
               errors++;
               $display("FAIL pulse_event got=%h required=%h", got_ev, exp_ev);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      bus.entrada = 4'hF;
      #1;
      chk("reset_outputs", {bus.pressao, bus.soltura, bus.longo, bus.estado}, 16'h0000);
      idle(3);
      RESET = 1'b1;
      idle(6);
      chk("idle_estado", {12'h000, bus.estado}, 16'h0000);

      press_hold(4'b0001, 12);   // basic press, one long strobe
      glitch(1, 3);              // rejected bounce
      press_hold(4'b0010, 4);    // shortest accepted press
      press_hold(4'b0100, 30);   // long press with auto-repeat
      for (int k = 0; k < 20; k++) begin
         @(negedge CLOCK);
         bus.entrada[3] = ((k / 2) % 2) != 0;
      end
      press_hold(4'b1000, 8);    // steady level after bouncing
      press_hold(4'b0011, 5);    // coincident strobes on two channels

      // reset in the middle of a hold, button kept pressed
      @(negedge CLOCK);
      r = cyc;
      exp_q.push_back(ev(r + DC + 2, 4'b0001, 4'b0, 4'b0, 4'b0001));
      bus.entrada[0] = 1'b0;
      idle(10);
      chk("estado_before_reset", {12'h000, bus.estado}, 16'h0001);
      #2 RESET = 1'b0;
      #1;
      chk("async_reset_outputs", {bus.pressao, bus.soltura, bus.longo, bus.estado}, 16'h0000);
      idle(3);
      RESET = 1'b1;
      r = cyc;
      exp_q.push_back(ev(r + 6,  4'b0001, 4'b0, 4'b0, 4'b0001));
      exp_q.push_back(ev(r + 16, 4'b0, 4'b0, 4'b0001, 4'b0001));
      exp_q.push_back(ev(r + 19, 4'b0, 4'b0, 4'b0001, 4'b0001));
      exp_q.push_back(ev(r + 22, 4'b0, 4'b0, 4'b0001, 4'b0001));
      exp_q.push_back(ev(r + 24, 4'b0, 4'b0001, 4'b0, 4'b0));
      idle(18);
      bus.entrada[0] = 1'b1;
      idle(12);

      for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge CLOCK);
      chk("queue_drained", 16'(exp_q.size()), 16'h0000);
      chk("final_estado", {12'h000, bus.estado}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debouncer_botoes.md
DEBOUNCER_BOTOES -- requirements
Module: debouncer_botoes

Interface
REQ-001 Parameter N, default 4: number of independent button channels, N >= 1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change, >= 1.
REQ-003 Parameter HOLD_CYCLES, default 1000: cycles a press must be held before the first long-press pulse, >= 1.
REQ-004 Parameter REPEAT_CYCLES, default 0: auto-repeat period for long-press pulses while held; 0 disables repeat.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means a raw input level of 0 is pressed; 0 means a raw input level of 1 is pressed.
REQ-006 CLOCK  input  1  single system clock; all state is updated on its rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of CLOCK.
REQ-008 entrada  input  N  raw asynchronous button levels, one bit per channel.
REQ-009 pressao  output  N  one-cycle pulse per channel on an accepted press.
REQ-010 soltura  output  N  one-cycle pulse per channel on an accepted release.
REQ-011 longo  output  N  one-cycle pulse per channel on long press and on each auto-repeat.
REQ-012 estado  output  N  debounced level per channel; 1 = pressed.

Function
REQ-013 Channels SHALL be fully independent; no state is shared across bits.
REQ-014 Each channel SHALL normalise polarity per ACTIVE_LOW, then pass the signal through a two-flip-flop synchroniser (s1, s2).
REQ-015 Debounce counter: clears when s2 == estado; increments when s2 != estado; at count == DEBOUNCE_CYCLES-1 with s2 != estado, estado <= s2 and the counter clears.
REQ-016 Latency: when edge 1 is the first edge sampling a new stable raw level, estado SHALL change at edge DEBOUNCE_CYCLES+2.
REQ-017 A raw level change reverting before it has been seen at s2 for DEBOUNCE_CYCLES consecutive cycles SHALL NOT change estado or produce any pulse.
REQ-018 pressao[i] SHALL be registered and high for exactly the cycle following the edge where estado[i] goes 0->1; soltura[i] SHALL behave identically for 1->0.
REQ-019 Hold counter (width clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)): cleared while estado = 0; counts while estado = 1.
REQ-020 Long press: if estado rises at edge E and stays high, longo SHALL pulse one cycle after edge E+HOLD_CYCLES.
REQ-021 Repeat, REPEAT_CYCLES > 0: while still held, longo SHALL pulse again every REPEAT_CYCLES cycles after the previous longo pulse.
REQ-022 Repeat, REPEAT_CYCLES = 0: the hold counter SHALL saturate, with exactly one longo pulse per press.
REQ-023 A release before HOLD_CYCLES SHALL produce soltura only; a release at any time SHALL clear the hold counter in the same edge estado falls.
REQ-024 pressao, soltura and longo SHALL never be high simultaneously on the same channel; pulses on different channels MAY coincide.
REQ-025 Counters SHALL never wrap around.

Reset
REQ-026 RESET = 0 SHALL asynchronously clear s1, s2, all counters, estado, pressao, soltura and longo to 0.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abandon that operation, with no pulse on release of reset.
REQ-028 After reset release, a button held throughout reset SHALL be treated as a new press: pressao SHALL pulse after DEBOUNCE_CYCLES+2 edges.

Verification (N=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1)
REQ-029 entrada[0] 1->0 held -> estado[0]=1 at edge 6, pressao[0] high one cycle, other channels 0.
REQ-030 entrada[1] low for 3 cycles then high -> estado, pressao, soltura and longo on channel 1 all stay 0.
REQ-031 entrada[2] held low 30 cycles, rise at edge E -> longo[2] pulses after E+10, E+13, E+16, E+19...; on release, soltura[2] pulses once and longo stops.
REQ-032 entrada[3] bouncing 0/1 every 2 cycles for 20 cycles, then steady 0 -> exactly one pressao[3] pulse, 6 edges after the steady level starts.
REQ-033 Press accepted, RESET pulsed low mid-hold with button kept low -> all outputs 0 at once; after release, one pressao 6 edges later, and longo 10 edges after that.
